// File: rtl/sa_pkg.sv
// sa_pkg: shared sizes and FSM state for the
// input-stationary tile driver.
package sa_pkg;

    localparam int SA_INPUT_WIDTH    = 16;
    localparam int SA_WEIGHT_WIDTH   = 16;
    localparam int SA_PSUM_WIDTH     = 32;
    localparam int SA_ARRAY_HEIGHT   = 4;
    localparam int SA_ARRAY_WIDTH    = 4;
    localparam int SA_RESULT_LATENCY = 6;
    localparam int SA_OUT_FIFO_DEPTH = 8;
    localparam int SA_ROW_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN
    } sa_state_e;

endpackage

// File: rtl/sa_is_tile_driver_if.sv
// sa_is_tile_driver_if: ifmap, weight and result
// streams between tile buffer and tile driver.
interface sa_is_tile_driver_if
    import sa_pkg::*;
#(
    parameter int INPUT_WIDTH  = SA_INPUT_WIDTH,
    parameter int WEIGHT_WIDTH = SA_WEIGHT_WIDTH,
    parameter int PSUM_WIDTH   = SA_PSUM_WIDTH,
    parameter int ARRAY_HEIGHT = SA_ARRAY_HEIGHT,
    parameter int ARRAY_WIDTH  = SA_ARRAY_WIDTH
);

    logic                                  in_valid;
    logic                                  in_ready;
    logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0]   in_data;

    logic                                  w_valid;
    logic                                  w_ready;
    logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]   w_data;

    logic                                  out_valid;
    logic                                  out_ready;
    logic [ARRAY_WIDTH*PSUM_WIDTH-1:0]     out_data;
    logic                                  out_last;

    modport master (
        output in_valid, in_data,
        output w_valid, w_data,
        output out_ready,
        input  in_ready, w_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data,
        input  w_valid, w_data,
        input  out_ready,
        output in_ready, w_ready,
        output out_valid, out_data, out_last
    );

endinterface

// File: rtl/sa_psum_fifo.sv
// sa_psum_fifo: registered-output-free sync FIFO,
// no fall-through, push and pop legal together.
module sa_psum_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem[rd_ptr];

    // storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // overflow means the upstream credit accounting broke
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && full && !pop)
    ) else $fatal(1, "sa_psum_fifo overflow");

endmodule

// File: rtl/sa_is_tile_driver.sv
// sa_is_tile_driver: loads an ifmap tile, streams
// weight rows, captures psum rows into a FIFO.
module sa_is_tile_driver
    import sa_pkg::*;
#(
    parameter int INPUT_WIDTH    = SA_INPUT_WIDTH,
    parameter int WEIGHT_WIDTH   = SA_WEIGHT_WIDTH,
    parameter int PSUM_WIDTH     = SA_PSUM_WIDTH,
    parameter int ARRAY_HEIGHT   = SA_ARRAY_HEIGHT,
    parameter int ARRAY_WIDTH    = SA_ARRAY_WIDTH,
    parameter int RESULT_LATENCY = SA_RESULT_LATENCY,
    parameter int OUT_FIFO_DEPTH = SA_OUT_FIFO_DEPTH,
    parameter int ROW_CNT_WIDTH  = SA_ROW_CNT_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [ROW_CNT_WIDTH-1:0]            num_rows,
    output logic                                busy,
    output logic                                done,
    sa_is_tile_driver_if.slave                  io,
    output logic                                input_en,
    output logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0] input_in,
    output logic                                process_en,
    output logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0] weight_in,
    input  logic [ARRAY_WIDTH*PSUM_WIDTH-1:0]   psum_out
);

    localparam int BW = $clog2(ARRAY_WIDTH + 1);
    localparam int DW = $clog2(RESULT_LATENCY + 2);
    localparam int CW = $clog2(OUT_FIFO_DEPTH) + 1;
    localparam int FW = ARRAY_WIDTH * PSUM_WIDTH + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(ARRAY_WIDTH - 1);
    localparam logic [DW-1:0] DRAIN_END = DW'(RESULT_LATENCY + 1);

    sa_state_e                 state;
    logic [ROW_CNT_WIDTH-1:0]  num_rows_q;
    logic [ROW_CNT_WIDTH-1:0]  rows_issued;
    logic [ROW_CNT_WIDTH-1:0]  cap_idx;
    logic [BW-1:0]             beat_cnt;
    logic [DW-1:0]             drain_cnt;
    logic                      in_ready_q;
    logic [RESULT_LATENCY:0]   tag_line;
    logic [CW-1:0]             fifo_count;
    logic [FW-1:0]             fifo_head;
    logic                      fifo_empty;
    logic                      start_acc;
    logic                      credit_ok;
    logic                      w_hs;
    logic                      cap;
    logic                      pop;

    assign start_acc   = (state == IDLE) && start && (num_rows != '0);
    // tag_line[0] sits beside weight_in, so every row still
    // owed a FIFO slot is counted here
    assign credit_ok   = (int'(fifo_count) + $countones(tag_line))
                         < OUT_FIFO_DEPTH;
    assign io.w_ready  = (state == STREAM)
                         && (rows_issued < num_rows_q) && credit_ok;
    assign io.in_ready = in_ready_q;
    assign w_hs        = io.w_valid && io.w_ready;
    assign cap         = tag_line[RESULT_LATENCY];
    assign pop         = io.out_valid && io.out_ready;

    // tile sequencer with registered array-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_ready_q  <= 1'b0;
            input_en    <= 1'b0;
            input_in    <= '0;
            process_en  <= 1'b0;
            weight_in   <= '0;
            num_rows_q  <= '0;
            rows_issued <= '0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
        end else begin
            done     <= 1'b0;
            input_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    process_en <= 1'b0;
                    weight_in  <= '0;
                    if (start_acc) begin
                        num_rows_q  <= num_rows;
                        rows_issued <= '0;
                        beat_cnt    <= '0;
                        drain_cnt   <= '0;
                        busy        <= 1'b1;
                        in_ready_q  <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (io.in_valid && in_ready_q) begin
                        input_in <= io.in_data;
                        input_en <= 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            in_ready_q <= 1'b0;
                            state      <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    process_en <= 1'b1;
                    if (w_hs) begin
                        weight_in   <= io.w_data;
                        rows_issued <= rows_issued + 1'b1;
                        if (rows_issued == num_rows_q - 1'b1) begin
                            state <= DRAIN;
                        end
                    end else begin
                        weight_in <= '0;
                    end
                end
                DRAIN: begin
                    weight_in <= '0;
                    if (drain_cnt == DRAIN_END) begin
                        process_en <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        process_en <= 1'b1;
                        drain_cnt  <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // row tags travel alongside the array latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_line <= '0;
        end else begin
            tag_line <= {tag_line[RESULT_LATENCY-1:0], w_hs};
        end
    end

    // capture index drives the last flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_idx <= '0;
        end else if (start_acc) begin
            cap_idx <= '0;
        end else if (cap) begin
            cap_idx <= cap_idx + 1'b1;
        end
    end

    sa_psum_fifo #(
        .WIDTH (FW),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap),
        .push_data ({cap_idx == num_rows_q - 1'b1, psum_out}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign io.out_valid = !fifo_empty;
    assign io.out_data  = fifo_empty ? '0 : fifo_head[FW-2:0];
    assign io.out_last  = !fifo_empty && fifo_head[FW-1];

endmodule

// File: tb/tb_sa_is_tile_driver.sv
// tb_sa_is_tile_driver: random tiles against a stub
// array and a row-order reference model.
module tb_sa_is_tile_driver;
    import sa_pkg::*;

    localparam int IW  = SA_INPUT_WIDTH;
    localparam int WW  = SA_WEIGHT_WIDTH;
    localparam int PW  = SA_PSUM_WIDTH;
    localparam int AH  = SA_ARRAY_HEIGHT;
    localparam int AW  = SA_ARRAY_WIDTH;
    localparam int L   = SA_RESULT_LATENCY;
    localparam int RCW = SA_ROW_CNT_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [RCW-1:0] num_rows;
    logic busy, done, input_en, process_en;
    logic [AH*IW-1:0] input_in;
    logic [AW*WW-1:0] weight_in;
    logic [AW*PW-1:0] psum_out;

    sa_is_tile_driver_if io ();

    sa_is_tile_driver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_rows   (num_rows),
        .busy       (busy),
        .done       (done),
        .io         (io),
        .input_en   (input_en),
        .input_in   (input_in),
        .process_en (process_en),
        .weight_in  (weight_in),
        .psum_out   (psum_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_mode = 1;

    logic [AH*IW-1:0] beats [AW];
    logic [AW*WW-1:0] rows [16];
    logic [AH*IW-1:0] load_q [$];
    logic [AW*PW:0]   got_q [$];
    int w_acc    = 0;
    int done_cnt = 0;
    logic [AW*PW-1:0] stub_q [L];

    function automatic logic [AW*PW-1:0] widen(input logic [AW*WW-1:0] w);
        logic signed [WW-1:0] e;
        logic [AW*PW-1:0] r;
        for (int c = 0; c < AW; c++) begin
            e = w[c*WW +: WW];
            r[c*PW +: PW] = PW'(e);
        end
        return r;
    endfunction

    function automatic logic [63:0] pack4(input int a, b, c, d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stub array: delayed sign-extended weights while processing
    always @(posedge clk) begin
        stub_q[0] <= process_en ? widen(weight_in) : '0;
        for (int k = 1; k < L; k++) stub_q[k] <= stub_q[k-1];
    end
    assign psum_out = stub_q[L-1];

    // result consumer: held low, held high or random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       io.out_ready = 1'b0;
            1:       io.out_ready = 1'b1;
            default: io.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // monitor: handshakes complete at the following edge
    always @(negedge clk) begin
        if (input_en) load_q.push_back(input_in);
        if (io.out_valid && io.out_ready)
            got_q.push_back({io.out_last, io.out_data});
        if (io.w_valid && io.w_ready) w_acc++;
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string p);
        check({p, "_busy"},   busy, 0);
        check({p, "_done"},   done, 0);
        check({p, "_in_en"},  input_en, 0);
        check({p, "_proc"},   process_en, 0);
        check({p, "_in_rdy"}, io.in_ready, 0);
        check({p, "_w_rdy"},  io.w_ready, 0);
        check({p, "_o_vld"},  io.out_valid, 0);
        check({p, "_o_last"}, io.out_last, 0);
        check({p, "_in_in"},  input_in, 0);
        check({p, "_w_in"},   weight_in, 0);
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        num_rows = RCW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic load_beats();
        int i = 0;
        int guard = 0;
        logic r;
        while (i < AW && guard < 200) begin
            io.in_valid = 1'b1;
            io.in_data = beats[i];
            @(negedge clk);
            r = io.in_ready;
            tick();
            if (r) i++;
            guard++;
        end
        io.in_valid = 1'b0;
        check("beats_sent", i, AW);
    endtask

    task automatic drive_rows(input int n, input int wmode);
        logic [6:0] pat = 7'b1011001;
        int i = 0;
        int cyc = 0;
        logic v, r;
        while (i < n && cyc < 2000) begin
            case (wmode)
                0:       v = 1'b1;
                1:       v = pat[cyc % 7];
                default: v = 1'($urandom_range(0, 1));
            endcase
            io.w_valid = v;
            io.w_data = v ? rows[i] : {$urandom, $urandom};
            @(negedge clk);
            r = io.w_ready;
            tick();
            if (v && r) i++;
            cyc++;
        end
        io.w_valid = 1'b0;
        check("rows_sent", i, n);
    endtask

    task automatic run_tile(input int n, input int wmode);
        int lb = load_q.size();
        int gb = got_q.size();
        int db = done_cnt;
        int t = 0;
        pulse_start(n);
        load_beats();
        drive_rows(n, wmode);
        while (done_cnt == db && t < 1000) begin tick(); t++; end
        t = 0;
        while (got_q.size() - gb < n && t < 1000) begin tick(); t++; end
        repeat (5) tick();
        check("n_out", got_q.size() - gb, n);
        check("done_once", done_cnt - db, 1);
        check("busy_end", busy, 0);
        check("n_beats", load_q.size() - lb, AW);
        for (int i = 0; i < AW; i++)
            if (lb + i < load_q.size())
                check("beat", load_q[lb+i], beats[i]);
        for (int i = 0; i < n; i++)
            if (gb + i < got_q.size()) begin
                check("row", got_q[gb+i][AW*PW-1:0], widen(rows[i]));
                check("last", got_q[gb+i][AW*PW], i == n - 1);
            end
    endtask

    task automatic rand_tile(input int n);
        for (int i = 0; i < AW; i++) beats[i] = {$urandom, $urandom};
        for (int i = 0; i < n; i++) rows[i] = {$urandom, $urandom};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int wb, db;
        rst_n = 1'b0;
        start = 1'b0;
        num_rows = '0;
        io.in_valid = 1'b0;
        io.in_data = '0;
        io.w_valid = 1'b0;
        io.w_data = '0;
        repeat (3) tick();
        check_idle("rst");
        rst_n = 1'b1;
        tick();

        beats[0] = pack4(1, 2, 3, 4);
        beats[1] = pack4(5, 6, 7, 8);
        beats[2] = pack4(9, 10, 11, 12);
        beats[3] = pack4(13, 14, 15, 16);
        rows[0] = pack4(4, 3, 2, 1);
        rows[1] = pack4(8, 7, 6, 5);
        rows[2] = pack4(12, 11, 10, 9);
        rows[3] = pack4(16, 15, 14, 13);
        run_tile(4, 0);

        rand_tile(4);
        run_tile(4, 1);

        rand_tile(12);
        ready_mode = 0;
        wb = w_acc;
        fork
            run_tile(12, 0);
            begin
                repeat (80) tick();
                check("bp_rows", w_acc - wb, 8);
                check("bp_w_rdy", io.w_ready, 0);
                ready_mode = 1;
            end
        join

        rand_tile(5);
        fork
            run_tile(5, 0);
            begin
                repeat (12) tick();
                check("busy_mid", busy, 1);
                start = 1'b1;
                num_rows = RCW'(3);
                tick();
                start = 1'b0;
            end
        join
        db = done_cnt;
        repeat (30) tick();
        check("no_2nd_busy", busy, 0);
        check("no_2nd_done", done_cnt - db, 0);

        db = done_cnt;
        pulse_start(0);
        check("zero_busy", busy, 0);
        repeat (20) tick();
        check("zero_busy2", busy, 0);
        check("zero_done", done_cnt - db, 0);

        rand_tile(4);
        db = done_cnt;
        pulse_start(4);
        load_beats();
        drive_rows(2, 0);
        rst_n = 1'b0;
        #1;
        check_idle("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        repeat (15) tick();
        check("rst_no_done", done_cnt - db, 0);
        check("rst_no_out", io.out_valid, 0);
        rows[0] = pack4(7, 7, 7, 7);
        run_tile(1, 0);

        for (int k = 0; k < 6; k++) begin
            int n = $urandom_range(1, 10);
            rand_tile(n);
            ready_mode = (k % 2 == 1) ? 2 : 1;
            run_tile(n, $urandom_range(0, 2));
        end
        ready_mode = 1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_is_tile_driver.md
Name: sa_is_tile_driver

Overview:
- Initiator side of the input-stationary systolic array interface: `input_en`/`input_in`, `process_en`/`weight_in`, `psum_out`.
- Takes an ifmap tile and a stream of weight rows over valid/ready, sequences the array load and process phases, and tracks every row through the fixed array latency.
- Captures the matching `psum_out` rows into an output FIFO with valid/ready and a last flag.
- Sits between the tile buffer/DMA and the `systolic_array_with_skew` instance.

Parameters:
- INPUT_WIDTH, 16, ifmap element width (signed)
- WEIGHT_WIDTH, 16, weight element width (signed)
- PSUM_WIDTH, 32, partial-sum width (signed)
- ARRAY_HEIGHT, 4, ifmap elements per load beat
- ARRAY_WIDTH, 4, weights per row = psums per result row = number of load beats
- RESULT_LATENCY, 6, cycles from the edge sampling a weight row with `process_en`=1 to its psum row being valid on `psum_out`; must be ≥1
- OUT_FIFO_DEPTH, 8, result FIFO entries (power of 2, ≥2)
- ROW_CNT_WIDTH, 16, width of the weight-row count

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run a tile
- num_rows  in  ROW_CNT_WIDTH  weight rows for this tile; sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the tile is complete
- in_valid / in_ready  in/out  1  ifmap load-beat handshake
- in_data  in  ARRAY_HEIGHT*INPUT_WIDTH  load beat; element i at [i*INPUT_WIDTH +: INPUT_WIDTH]
- w_valid / w_ready  in/out  1  weight-row handshake
- w_data  in  ARRAY_WIDTH*WEIGHT_WIDTH  weight row, same packing
- input_en  out  1  to array
- input_in  out  ARRAY_HEIGHT*INPUT_WIDTH  to array
- process_en  out  1  to array
- weight_in  out  ARRAY_WIDTH*WEIGHT_WIDTH  to array
- psum_out  in  ARRAY_WIDTH*PSUM_WIDTH  from array
- out_valid / out_ready  out/in  1  result handshake
- out_data  out  ARRAY_WIDTH*PSUM_WIDTH  result row
- out_last  out  1  qualifies the result of the final row

Behaviour:
- Reset (async, immediate): state IDLE. busy, done, input_en, process_en, in_ready, w_ready, out_valid, out_last = 0. input_in, weight_in = 0. FIFO emptied, counters and tag line cleared.
- Reset mid-tile: the tile is abandoned, no done pulse, all in-flight results are dropped.
- FSM: IDLE -> LOAD -> STREAM -> DRAIN -> IDLE.
- IDLE:
  - start with num_rows ≠ 0 is accepted: latch num_rows, busy=1, go to LOAD.
  - start with num_rows = 0 is ignored.
  - start while busy is ignored.
- LOAD:
  - in_ready=1.
  - On each handshake, input_in and input_en=1 are registered so they reach the array on the following cycle; input_en=0 on non-handshake cycles.
  - After ARRAY_WIDTH beats, go to STREAM.
- STREAM:
  - process_en=1 every cycle, registered with weight_in.
  - w_ready = (rows_issued < num_rows) && (fifo_count + inflight < OUT_FIFO_DEPTH).
  - Handshake: weight_in = w_data, tag=1. No handshake: weight_in = 0, tag=0 (bubble).
  - The tag enters a RESULT_LATENCY-deep shift line aligned with the registered weight_in.
  - `inflight` counts tag=1 entries in the line.
  - After the num_rows-th handshake, go to DRAIN.
- DRAIN:
  - process_en=1 and weight_in=0 for RESULT_LATENCY+1 cycles, then done=1 for one cycle, busy=0, state IDLE.
  - The FIFO may still hold results after done.
- Capture: when the line output tag=1, push psum_out into the FIFO with last = (capture index == num_rows-1).
  - The credit rule guarantees the FIFO is never full on a push; an overflow is a fatal assertion in simulation.
- Output FIFO:
  - out_valid = !empty; out_data/out_last come from the head.
  - A simultaneous push and pop is legal at any count, including full and empty.
  - No fall-through: a result appears one cycle after the push.
- Ordering: results are emitted in weight-row order, one per accepted row, exactly num_rows per tile.
- Arithmetic: pure data movement, no width conversion; psum_out is taken verbatim.

Decomposition:
- Package `sa_pkg`: width/size localparams and the FSM state enum {IDLE, LOAD, STREAM, DRAIN}.
- Sub-module `sa_psum_fifo`: a synchronous FIFO parameterised by data width and depth, with count output, same async reset.

Test Plan:
Bench uses a stub array: psum_out[c] = sign-extended weight_in[c] delayed RESULT_LATENCY cycles while process_en is high; load beats are recorded by a monitor.
- Basic tile:
  - Stimulus: start, num_rows=4; load beats {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} back-to-back; weight rows {4,3,2,1},{8,7,6,5},{12,11,10,9},{16,15,14,13}; out_ready=1.
  - Response: input_en high exactly 4 cycles carrying those beats; 4 outputs equal to the rows in order; out_last only on the 4th; done once, after the last capture.
- Weight bubbles:
  - Stimulus: w_valid toggled 1,0,0,1,1,0,1.
  - Response: exactly 4 results, no zero rows emitted, order preserved.
- Backpressure:
  - Stimulus: out_ready=0, num_rows=12, OUT_FIFO_DEPTH=8.
  - Response: w_ready drops after 8 accepted rows; no overflow. Release out_ready -> all 12 results emitted in order, last on the 12th.
- Guard cases:
  - start while busy: ignored, no second tile.
  - start with num_rows=0: busy stays 0, no done.
- Reset mid-STREAM: assert rst_n=0 after 2 rows -> all outputs 0 immediately. A new tile of 1 row {7,7,7,7} -> a single result {7,7,7,7} with out_last=1.
